// File: rtl/bsg_nonsynth_dma_model_multi.sv
// bsg_nonsynth_dma_model_multi: shared word-addressed block memory serving
// num_dma_p cache DMA channels, one transfer at a time, round-robin granted.
// Optional masked commits are enabled by defining BSG_NONSYNTH_DMA_MODEL_MASK_EN.
module bsg_nonsynth_dma_model_multi #(
  parameter int addr_width_p          = 30,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int els_p                 = 1024,
  parameter int num_dma_p             = 2,
  parameter int read_delay_p          = 16,
  parameter int write_delay_p         = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [num_dma_p-1:0]                       dma_pkt_v_i,
  input  logic [num_dma_p-1:0]                       dma_pkt_write_i,
  input  logic [num_dma_p*addr_width_p-1:0]          dma_pkt_addr_i,
  input  logic [num_dma_p*block_size_in_words_p-1:0] dma_pkt_mask_i,
  output logic [num_dma_p-1:0]                       dma_pkt_yumi_o,
  output logic [data_width_p-1:0]                    dma_data_o,
  output logic [num_dma_p-1:0]                       dma_data_v_o,
  input  logic [num_dma_p-1:0]                       dma_data_ready_i,
  input  logic [num_dma_p*data_width_p-1:0]          dma_data_i,
  input  logic [num_dma_p-1:0]                       dma_data_v_i,
  output logic [num_dma_p-1:0]                       dma_data_yumi_o
);

  localparam int unsigned lg_bytes_lp  = $clog2(data_width_p / 8);
  localparam int unsigned lg_els_lp    = $clog2(els_p);
  localparam int unsigned lg_block_lp  = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam int unsigned lg_ch_lp     = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
  localparam int unsigned max_delay_lp = (read_delay_p > write_delay_p) ? read_delay_p : write_delay_p;
  localparam int unsigned dly_w_lp     = (max_delay_lp > 0) ? $clog2(max_delay_lp + 1) : 1;

  localparam logic [lg_block_lp-1:0] last_word_lp = lg_block_lp'(block_size_in_words_p - 1);
  localparam logic [lg_els_lp-1:0]   blk_mask_lp  = lg_els_lp'(block_size_in_words_p - 1);
  localparam logic [dly_w_lp-1:0]    rd_last_lp   = dly_w_lp'(read_delay_p - 1);
  localparam logic [dly_w_lp-1:0]    wr_last_lp   = dly_w_lp'(write_delay_p - 1);
  localparam logic [lg_ch_lp-1:0]    last_ch_lp   = lg_ch_lp'(num_dma_p - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_RECV,
    S_WR_WAIT
  } state_e;

  state_e                               r_state;
  logic [lg_ch_lp-1:0]                  r_rr;
  logic [lg_ch_lp-1:0]                  r_ch;
  logic [lg_block_lp-1:0]               r_cnt;
  logic [dly_w_lp-1:0]                  r_dly;
  logic [lg_els_lp-1:0]                 r_base;
  logic [block_size_in_words_p-1:0]     r_mask;
  logic [data_width_p-1:0]              r_buf [block_size_in_words_p];
  logic [data_width_p-1:0]              r_mem [els_p];

  logic [addr_width_p-1:0]              w_addr_arr  [num_dma_p];
  logic [block_size_in_words_p-1:0]     w_mask_arr  [num_dma_p];
  logic [data_width_p-1:0]              w_wdata_arr [num_dma_p];
  logic                                 w_grant_v;
  logic [lg_ch_lp-1:0]                  w_grant;
  logic                                 w_hi_v;
  logic [lg_ch_lp-1:0]                  w_hi;
  logic [lg_els_lp-1:0]                 w_base;
  logic [data_width_p-1:0]              w_wdata;
  logic [block_size_in_words_p-1:0]     w_word_en;

  // split the flattened per-channel buses into arrays
  for (genvar c = 0; c < num_dma_p; c++) begin : g_split
    assign w_addr_arr[c]  = dma_pkt_addr_i[c*addr_width_p +: addr_width_p];
    assign w_mask_arr[c]  = dma_pkt_mask_i[c*block_size_in_words_p +: block_size_in_words_p];
    assign w_wdata_arr[c] = dma_data_i[c*data_width_p +: data_width_p];
  end

  // block-aligned word index of the granted request, wrapped into the array
  assign w_base  = lg_els_lp'(w_addr_arr[w_grant] >> lg_bytes_lp) & ~blk_mask_lp;
  assign w_wdata = w_wdata_arr[r_ch];

`ifdef BSG_NONSYNTH_DMA_MODEL_MASK_EN
  assign w_word_en = r_mask;
`else
  // mask is latched in both builds; this build writes every word regardless
  assign w_word_en = r_mask | ~r_mask;
`endif

  // round-robin arbiter: first valid at or above rr, else lowest valid overall
  always_comb begin
    w_grant_v = 1'b0;
    w_grant   = '0;
    w_hi_v    = 1'b0;
    w_hi      = '0;
    for (int c = num_dma_p - 1; c >= 0; c--) begin
      if (dma_pkt_v_i[c]) begin
        w_grant_v = 1'b1;
        w_grant   = lg_ch_lp'(c);
        if (lg_ch_lp'(c) >= r_rr) begin
          w_hi_v = 1'b1;
          w_hi   = lg_ch_lp'(c);
        end
      end
    end
    if (w_hi_v) w_grant = w_hi;
  end

  // handshake outputs decoded from state; all held low during reset
  always_comb begin
    dma_pkt_yumi_o  = '0;
    dma_data_v_o    = '0;
    dma_data_o      = '0;
    dma_data_yumi_o = '0;
    if (!reset) begin
      case (r_state)
        S_IDLE:    if (w_grant_v) dma_pkt_yumi_o[w_grant] = 1'b1;
        S_RD_SEND: begin
          dma_data_v_o[r_ch] = 1'b1;
          dma_data_o         = r_buf[r_cnt];
        end
        S_WR_RECV: dma_data_yumi_o[r_ch] = dma_data_v_i[r_ch];
        default:   ;
      endcase
    end
  end

  // transfer FSM, staging buffer and backing memory
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_dly   <= '0;
      r_base  <= '0;
      r_mask  <= '0;
      for (int i = 0; i < els_p; i++) r_mem[i] <= data_width_p'(i);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_v) begin
            r_ch   <= w_grant;
            r_base <= w_base;
            r_mask <= w_mask_arr[w_grant];
            r_cnt  <= '0;
            r_dly  <= '0;
            r_rr   <= (w_grant == last_ch_lp) ? '0 : w_grant + 1'b1;
            if (dma_pkt_write_i[w_grant]) begin
              r_state <= S_WR_RECV;
            end else if (read_delay_p > 0) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_state <= S_RD_SEND;
              for (int i = 0; i < block_size_in_words_p; i++)
                r_buf[i] <= r_mem[w_base | lg_els_lp'(i)];
            end
          end
        end
        S_RD_WAIT: begin
          if (r_dly == rd_last_lp) begin
            r_state <= S_RD_SEND;
            for (int i = 0; i < block_size_in_words_p; i++)
              r_buf[i] <= r_mem[r_base | lg_els_lp'(i)];
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        S_RD_SEND: begin
          if (dma_data_ready_i[r_ch]) begin
            if (r_cnt == last_word_lp) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WR_RECV: begin
          if (dma_data_v_i[r_ch]) begin
            r_buf[r_cnt] <= w_wdata;
            if (r_cnt == last_word_lp) begin
              r_cnt <= '0;
              r_dly <= '0;
              if (write_delay_p > 0) begin
                r_state <= S_WR_WAIT;
              end else begin
                // commit now; the last word bypasses the buffer
                r_state <= S_IDLE;
                for (int i = 0; i < block_size_in_words_p; i++)
                  if (w_word_en[i]) r_mem[r_base | lg_els_lp'(i)] <= r_buf[i];
                if (w_word_en[r_cnt]) r_mem[r_base | lg_els_lp'(r_cnt)] <= w_wdata;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WR_WAIT: begin
          if (r_dly == wr_last_lp) begin
            r_state <= S_IDLE;
            for (int i = 0; i < block_size_in_words_p; i++)
              if (w_word_en[i]) r_mem[r_base | lg_els_lp'(i)] <= r_buf[i];
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_nonsynth_dma_model_multi.sv
// Self-checking bench for bsg_nonsynth_dma_model_multi (2 channels, 32-bit words,
// 8-word blocks, 1024 words). The reference is a plain word array updated per transfer.
module tb_bsg_nonsynth_dma_model_multi;

  localparam int RD   = 4;
  localparam int WR   = 3;
  localparam int BLK  = 8;
  localparam int ELS  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pkt_v, pkt_write, rdy, wv;
  logic [29:0] pkt_addr [2];
  logic [7:0]  pkt_mask [2];
  logic [31:0] wd [2];
  logic [59:0] addr_flat;
  logic [15:0] mask_flat;
  logic [63:0] wd_flat;
  logic [1:0]  yumi, dv, wy;
  logic [31:0] dout;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] mem_model [ELS];

  assign addr_flat = {pkt_addr[1], pkt_addr[0]};
  assign mask_flat = {pkt_mask[1], pkt_mask[0]};
  assign wd_flat   = {wd[1], wd[0]};

  always #5 clk = ~clk;

  bsg_nonsynth_dma_model_multi #(
    .read_delay_p (RD),
    .write_delay_p(WR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .dma_pkt_v_i     (pkt_v),
    .dma_pkt_write_i (pkt_write),
    .dma_pkt_addr_i  (addr_flat),
    .dma_pkt_mask_i  (mask_flat),
    .dma_pkt_yumi_o  (yumi),
    .dma_data_o      (dout),
    .dma_data_v_o    (dv),
    .dma_data_ready_i(rdy),
    .dma_data_i      (wd_flat),
    .dma_data_v_i    (wv),
    .dma_data_yumi_o (wy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int blk_of(input logic [29:0] a);
    int w;
    w = int'(a >> 2) % ELS;
    return w - (w % BLK);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ELS; i++) mem_model[i] = 32'(i);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_yumi"}, yumi, 0);
    check({tag, "_dv"}, dv, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_wy"}, wy, 0);
  endtask

  // wait (bounded) for any request acceptance and compare the grant vector
  task automatic await_grant(input logic [1:0] exp, input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (yumi == 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, yumi, exp);
  endtask

  // receive nwords read words on ch; mode 0: ready held, 1: 1,0,0 pattern, 2: random
  task automatic collect_read(input int ch, input int base, input int mode, input bit clr,
                              input bit chk_lat, input int nwords);
    int got, cyc, first, last;
    logic [31:0] held;
    bit hold_chk;
    got = 0; cyc = 0; first = -1; last = -1; hold_chk = 0; held = '0;
    while (got < nwords && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && clr) pkt_v = 2'b00;
      case (mode)
        0:       rdy[ch] = 1'b1;
        1:       rdy[ch] = ((cyc % 3) == 1);
        default: rdy[ch] = 1'($urandom_range(0, 1));
      endcase
      rdy[1-ch] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dv != 2'b00) check("rd_onehot", dv, 64'(1 << ch));
      if (dv[ch]) begin
        if (first < 0) first = cyc;
        if (hold_chk) check("rd_hold", dout, held);
        if (rdy[ch]) begin
          check("rd_data", dout, mem_model[base + got]);
          got++;
          last = cyc;
          hold_chk = 0;
        end else begin
          held = dout;
          hold_chk = 1;
        end
      end
    end
    if (got < nwords) check("rd_timeout", got, nwords);
    if (chk_lat) begin
      check("rd_latency", first, RD + 1);
      check("rd_burst", last - first, BLK - 1);
    end
  endtask

  // feed 8 words on ch with random gaps; the other channel also offers data
  task automatic collect_write(input int ch, input int base, input logic [7:0] mask,
                               input logic [31:0] data [8], input bit clr);
    int n, cyc;
    n = 0; cyc = 0;
    while (n < BLK && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && clr) pkt_v = 2'b00;
      wv[ch]   = ($urandom_range(0, 3) != 0);
      wd[ch]   = data[n];
      wv[1-ch] = 1'b1;
      wd[1-ch] = $urandom;
      @(negedge clk);
      check("wr_yumi", wy, wv[ch] ? 64'(1 << ch) : 64'd0);
      if (wy[ch]) n++;
    end
    if (n < BLK) check("wr_timeout", n, BLK);
    @(posedge clk); #1;
    wv = 2'b00;
    for (int i = 0; i < BLK; i++) begin
`ifdef BSG_NONSYNTH_DMA_MODEL_MASK_EN
      if (mask[i]) mem_model[base + i] = data[i];
`else
      mem_model[base + i] = data[i];
`endif
    end
  endtask

  task automatic do_read(input int ch, input logic [29:0] addr, input int mode, input bit chk_lat);
    @(posedge clk); #1;
    pkt_v[ch] = 1'b1; pkt_write[ch] = 1'b0; pkt_addr[ch] = addr;
    await_grant(2'(1 << ch), "rd_grant");
    collect_read(ch, blk_of(addr), mode, 1'b1, chk_lat, BLK);
  endtask

  task automatic do_write(input int ch, input logic [29:0] addr, input logic [7:0] mask,
                          input logic [31:0] data [8]);
    @(posedge clk); #1;
    pkt_v[ch] = 1'b1; pkt_write[ch] = 1'b1; pkt_addr[ch] = addr; pkt_mask[ch] = mask;
    await_grant(2'(1 << ch), "wr_grant");
    collect_write(ch, blk_of(addr), mask, data, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d [8];
    logic [29:0] a;
    reset = 1'b1; pkt_v = '0; pkt_write = '0; rdy = '0; wv = '0;
    pkt_addr[0] = '0; pkt_addr[1] = '0; pkt_mask[0] = '0; pkt_mask[1] = '0;
    wd[0] = '0; wd[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");

    // both channels request in the first cycle after reset
    @(posedge clk); #1;
    reset = 1'b0;
    pkt_v = 2'b11; pkt_write = 2'b00;
    pkt_addr[0] = 30'h100; pkt_addr[1] = 30'h180;
    await_grant(2'b01, "arb_first");
    collect_read(0, blk_of(30'h100), 0, 1'b0, 1'b0, BLK);
    await_grant(2'b10, "arb_rr");
    collect_read(1, blk_of(30'h180), 0, 1'b0, 1'b0, BLK);
    await_grant(2'b01, "arb_wrap");
    collect_read(0, blk_of(30'h100), 0, 1'b1, 1'b0, BLK);

    // read latency and burst shape
    do_read(0, 30'h40, 0, 1'b1);

    // write ch1 then unaligned read ch0 of the same block
    for (int i = 0; i < BLK; i++) d[i] = 32'hA0 + 32'(i);
    do_write(1, 30'h80, 8'hFF, d);
    do_read(0, 30'h84, 0, 1'b0);

    // ready toggling 1,0,0,...
    do_read(1, 30'h300, 1, 1'b0);

    // masked write to block 0
    for (int i = 0; i < BLK; i++) d[i] = 32'hB0 + 32'(i);
    do_write(0, 30'h0, 8'h0F, d);
    do_read(0, 30'h0, 2, 1'b0);

    // reset in the middle of a read of a modified block
    for (int i = 0; i < BLK; i++) d[i] = $urandom;
    do_write(1, 30'h200, 8'hFF, d);
    @(posedge clk); #1;
    pkt_v[0] = 1'b1; pkt_write[0] = 1'b0; pkt_addr[0] = 30'h200;
    await_grant(2'b01, "rst_grant");
    collect_read(0, blk_of(30'h200), 0, 1'b1, 1'b0, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("rst_after");
    do_read(0, 30'h200, 0, 1'b0);

    // randomized mix of reads and writes, addresses wrapping onto a few blocks
    for (int t = 0; t < 24; t++) begin
      int ch;
      ch = $urandom_range(0, 1);
      a  = 30'(($urandom_range(0, 3) * 32) + $urandom_range(0, 31) + ($urandom_range(0, 1000) * 4096));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < BLK; i++) d[i] = $urandom;
        do_write(ch, a, 8'($urandom), d);
      end else begin
        do_read(ch, a, 2, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_nonsynth_dma_model_multi.md
Name: bsg_nonsynth_dma_model_multi

Overview:
- Non-synthesizable block-transfer memory model serving num_dma_p independent cache DMA channels from one shared word-addressed array.
- Successor to the single-channel DMA model used in cache regression benches; generalised in channel count.
- Adds round-robin arbitration across channels, per-transfer read/write latency, and optional masked writes.
- Sits behind one or more bsg_cache instances in testbenches; one transfer is serviced at a time, so the memory is trivially coherent across channels.

Parameters:
- addr_width_p, 30: byte address width.
- data_width_p, 32: word width; power of 2, at least 8.
- block_size_in_words_p, 8: words per transfer; power of 2.
- els_p, 1024: memory depth in words; power of 2, multiple of block_size_in_words_p.
- num_dma_p, 2: number of channels, at least 1.
- read_delay_p, 16: idle cycles between read accept and first read word; 0 allowed.
- write_delay_p, 16: idle cycles between last write word and commit; 0 allowed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dma_pkt_v_i  in  num_dma_p  per-channel request valid.
- dma_pkt_write_i  in  num_dma_p  1 = write, 0 = read.
- dma_pkt_addr_i  in  num_dma_p*addr_width_p  per-channel byte address.
- dma_pkt_mask_i  in  num_dma_p*block_size_in_words_p  per-word write mask.
- dma_pkt_yumi_o  out  num_dma_p  request accepted.
- dma_data_o  out  data_width_p  read data, shared across channels.
- dma_data_v_o  out  num_dma_p  read data valid, one-hot.
- dma_data_ready_i  in  num_dma_p  channel can take read data.
- dma_data_i  in  num_dma_p*data_width_p  write data.
- dma_data_v_i  in  num_dma_p  write data valid.
- dma_data_yumi_o  out  num_dma_p  write word consumed.

Behaviour:
- Reset values: all outputs 0; dma_data_o 0.
- Reset state: FSM in IDLE; round-robin pointer rr = 0; memory word i initialised to i, truncated to data_width_p.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0. A pending or partially received write is discarded. Memory is re-initialised.
- Addressing: word index = addr >> lg(data_width_p/8), taken modulo els_p. The low lg(block_size_in_words_p) bits of the word index are forced to 0 (block-aligned). Out-of-range addresses wrap.
- States: IDLE, RD_WAIT, RD_SEND, WR_RECV, WR_WAIT.
- IDLE: if any dma_pkt_v_i is set, grant g = first valid channel searching from rr upward, with wrap.
  - Assert dma_pkt_yumi_o[g] combinationally in that cycle; yumi depends on v.
  - Latch write flag, block address and mask; set rr = (g+1) mod num_dma_p; clear the word counter.
  - Next state is WR_RECV for a write. For a read it is RD_WAIT if read_delay_p > 0, else RD_SEND.
- RD_WAIT: count read_delay_p cycles, then go to RD_SEND. Snapshot the block from memory into the buffer on the transition.
- RD_SEND: dma_data_v_o[g] = 1 and dma_data_o = buf[cnt].
  - cnt advances only when dma_data_ready_i[g] is high.
  - After word block_size_in_words_p-1 transfers, go to IDLE.
  - Ready on other channels is ignored.
- WR_RECV: dma_data_yumi_o[g] = dma_data_v_i[g]. Each accepted word goes to buf[cnt], then cnt++.
  - After the last word, go to WR_WAIT if write_delay_p > 0; otherwise commit and go to IDLE in the same transition.
  - dma_data_v_i on other channels is never yumi'd.
- WR_WAIT: count write_delay_p cycles, commit the buffer to memory, go to IDLE.
- No new request is accepted in the cycle a commit occurs. A read granted afterwards sees the committed data.
- At most one bit of each one-hot output vector is set in any cycle.
- Delay counter width is lg(max(read_delay_p, write_delay_p) + 1).
- Word counter is lg(block_size_in_words_p) bits and wraps to 0 at transfer end.

Optional Feature:
- Macro: BSG_NONSYNTH_DMA_MODEL_MASK_EN.
- Defined: a commit writes only words whose latched mask bit is 1. All block_size_in_words_p words are still received over the data port.
- Undefined: dma_pkt_mask_i is ignored and every commit writes all words.

Test Plan:
- Read, ch0, addr 0x40, read_delay_p=4, ready held 1 -> yumi at the accept cycle; dma_data_v_o=01 from accept+5 for 8 consecutive cycles; data 16..23.
- Write ch1 addr 0x80 data 0xA0..0xA7, then read ch0 addr 0x84 -> yumi on ch1 for 8 words; read returns 0xA0..0xA7 (unaligned address block-aligned).
- Both channels request reads in the first cycle after reset -> ch0 granted first, ch1 next; a third back-to-back ch0+ch1 request grants ch0 (rr wrapped to 0).
- Read with dma_data_ready_i toggling 1,0,0,1,... -> exactly 8 distinct, in-order words; dma_data_o held stable while ready is 0.
- Mask 0x0F write of 0xB0..0xB7 to addr 0 -> with macro, readback is 0xB0..0xB3,4,5,6,7; without macro, readback is 0xB0..0xB7.
- Assert reset after 3 read words on ch0 -> outputs 0 on the next cycle; a new read of the same block returns initial values.
